// File: rtl/compare_arbiter.sv
// Round-robin front end sharing one external 32-bit comparator between two
// requesters: registers operands, waits one execute cycle, holds the result until consumed.
module compare_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_neq,
  input  logic             cmp_lt,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp0_result,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic             rsp1_result,
  output logic             busy,
  output logic [CNT_W-1:0] done0_cnt,
  output logic [CNT_W-1:0] done1_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   prio;
  logic   grant;
  logic   id;
  logic   op;
  logic   result;
  logic   accept;
  logic   rsp_hs;

  // Priority pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = prio;
    else if (req1_valid)          grant = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid && !grant;
        req1_ready = req1_valid && grant;
        if (req0_valid || req1_valid) state_nx = EXEC;
      end
      EXEC: state_nx = HOLD;
      HOLD: begin
        rsp0_valid = !id;
        rsp1_valid = id;
        if (id ? rsp1_ready : rsp0_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept      = req0_ready || req1_ready;
  assign rsp_hs      = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  assign busy        = (state != IDLE);
  assign rsp0_result = result;
  assign rsp1_result = result;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio      <= 1'b0;
      cmp_a     <= '0;
      cmp_b     <= '0;
      op        <= 1'b0;
      id        <= 1'b0;
      result    <= 1'b0;
      done0_cnt <= '0;
      done1_cnt <= '0;
    end else begin
      if (accept) begin
        cmp_a <= grant ? req1_a  : req0_a;
        cmp_b <= grant ? req1_b  : req0_b;
        op    <= grant ? req1_op : req0_op;
        id    <= grant;
        if (req0_valid && req1_valid) prio <= ~grant;
      end
      if (state == EXEC) result <= op ? cmp_lt : cmp_neq;
      if (rsp_hs) begin
        if (!id && done0_cnt != '1) done0_cnt <= done0_cnt + CNT_W'(1);
        if (id && done1_cnt != '1)  done1_cnt <= done1_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_compare_arbiter.sv
// Randomized scoreboard bench for compare_arbiter with a behavioural model of
// grant order, latency, results and saturating completion counts.
module tb_compare_arbiter;
  localparam int W  = 32;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 0, req1_valid = 0, req0_op = 0, req1_op = 0;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  cmp_a, cmp_b;
  logic          cmp_neq, cmp_lt;
  logic          rsp0_valid, rsp1_valid, rsp0_result, rsp1_result;
  logic          rsp0_ready = 0, rsp1_ready = 0;
  logic          busy;
  logic [CW-1:0] done0_cnt, done1_cnt;

  always #5 clock = ~clock;

  // External comparator
  assign cmp_neq = (cmp_a != cmp_b);
  assign cmp_lt  = ($signed(cmp_a) < $signed(cmp_b));

  compare_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_neq(cmp_neq), .cmp_lt(cmp_lt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .busy(busy), .done0_cnt(done0_cnt), .done1_cnt(done1_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int     id;
    logic   res;
    longint acc;
  } item_t;

  item_t       q[$];
  item_t       it;
  bit          inflight = 0;
  bit          prio = 0;
  int          cnt[2] = '{0, 0};
  logic [31:0] ma = '0, mb = '0;
  longint      cyc = 0;
  bit          g, acc0, acc1, ev;
  localparam int CMAX = (1 << CW) - 1;

  function automatic logic ref_cmp(input logic [31:0] a, input logic [31:0] b, input logic op);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    return op ? (sa < sb) : (a != b);
  endfunction

  // Predictor and monitor, sampled mid-cycle
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
      chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
      chk("rst_cmp_a", cmp_a, 0);
      chk("rst_done0", 32'(done0_cnt), 0);
      q.delete();
      inflight = 0; prio = 0; cnt = '{0, 0}; ma = '0; mb = '0;
    end else begin
      chk("busy", 32'(busy), 32'(inflight));
      chk("cmp_a", cmp_a, ma);
      chk("cmp_b", cmp_b, mb);
      chk("done0_cnt", 32'(done0_cnt), 32'(cnt[0]));
      chk("done1_cnt", 32'(done1_cnt), 32'(cnt[1]));
      g    = (req0_valid && req1_valid) ? prio : req1_valid;
      acc0 = !inflight && req0_valid && !g;
      acc1 = !inflight && req1_valid && g;
      chk("req0_ready", 32'(req0_ready), 32'(acc0));
      chk("req1_ready", 32'(req1_ready), 32'(acc1));
      if (inflight) begin
        it = q[0];
        ev = (cyc >= it.acc + 2);
        chk("rsp0_valid", 32'(rsp0_valid), 32'(ev && it.id == 0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(ev && it.id == 1));
        if (ev) begin
          chk("rsp_result", 32'(it.id == 1 ? rsp1_result : rsp0_result), 32'(it.res));
          if (it.id == 1 ? rsp1_ready : rsp0_ready) begin
            if (cnt[it.id] < CMAX) cnt[it.id]++;
            void'(q.pop_front());
            inflight = 0;
          end
        end
      end else begin
        chk("idle_rsp0_valid", 32'(rsp0_valid), 0);
        chk("idle_rsp1_valid", 32'(rsp1_valid), 0);
      end
      if (acc0 || acc1) begin
        it.id  = acc1 ? 1 : 0;
        it.res = acc1 ? ref_cmp(req1_a, req1_b, req1_op) : ref_cmp(req0_a, req0_b, req0_op);
        it.acc = cyc;
        q.push_back(it);
        ma = acc1 ? req1_a : req0_a;
        mb = acc1 ? req1_b : req0_b;
        if (req0_valid && req1_valid) prio = ~g;
        inflight = 1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input logic op);
    bit got = 0;
    if (id == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    else         begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clock);
      got = (id == 0) ? req0_ready : req1_ready;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL issue_timeout: req%0d never accepted", id); end
    @(posedge clock); #1;
    if (id == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  function automatic logic [31:0] rnd_b(input logic [31:0] a);
    case ($urandom_range(3))
      0:       return a;
      1:       return a ^ (32'h1 << $urandom_range(31));
      2:       return ~a;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    idle(3);
    reset = 0;

    // Reset while a result is held
    rsp0_ready = 0; rsp1_ready = 1;
    issue(0, 32'd5, 32'd5, 1'b0);
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin @(negedge clock); seen = rsp0_valid; end
    chk("hold_reached", 32'(seen), 1);
    @(posedge clock); #1;
    reset = 1;
    #1;
    chk("async_rsp0_valid", 32'(rsp0_valid), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_cmp_a", cmp_a, 0);
    chk("async_done0", 32'(done0_cnt), 0);
    idle(2);
    reset = 0; rsp0_ready = 1;
    idle(6);

    // Directed single requests
    issue(0, 32'h1234, 32'h1235, 1'b0);     idle(4);
    issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); idle(4);
    issue(1, 32'hFFFFFFFF, 32'h00000001, 1'b1); idle(4);
    issue(1, 32'h7FFFFFFF, 32'h80000000, 1'b1); idle(4);

    // Contention with changing operands
    for (int i = 0; i < 30; i++) begin
      req0_valid = 1; req1_valid = 1;
      req0_a = $urandom; req0_b = rnd_b(req0_a); req0_op = 1'($urandom);
      req1_a = $urandom; req1_b = rnd_b(req1_a); req1_op = 1'($urandom);
      idle(1);
    end
    req0_valid = 0; req1_valid = 0;
    idle(4);

    // Backpressure with a waiting requester
    rsp0_ready = 0;
    issue(0, 32'h10, 32'h20, 1'b1);
    req1_valid = 1; req1_a = 32'h3; req1_b = 32'h3; req1_op = 0;
    idle(7);
    rsp0_ready = 1;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin @(negedge clock); seen = req1_ready; end
    chk("bp_req1_accepted", 32'(seen), 1);
    @(posedge clock); #1;
    req1_valid = 0;
    idle(4);

    // Random traffic; counters saturate along the way
    for (int i = 0; i < 600; i++) begin
      req0_valid = ($urandom_range(3) != 0);
      req1_valid = ($urandom_range(3) != 0);
      req0_a = $urandom; req0_b = rnd_b(req0_a); req0_op = 1'($urandom);
      req1_a = $urandom; req1_b = rnd_b(req1_a); req1_op = 1'($urandom);
      rsp0_ready = ($urandom_range(2) != 0);
      rsp1_ready = ($urandom_range(2) != 0);
      idle(1);
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    idle(8);
    chk("final_done0_saturated", 32'(done0_cnt), CMAX);
    chk("final_done1_saturated", 32'(done1_cnt), CMAX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/compare_arbiter.md
Name: compare_arbiter

Overview:
Shares one external 32-bit comparator (not-equal and signed less-than outputs) between two requesters, e.g. branch resolution and a debug/trap checker. Round-robin grant, operand registering, a fixed-latency execute cycle and per-requester response handshake. Sits between requesters and the comparator instance; the comparator itself stays outside this block.

Parameters:
WIDTH, 32, operand width in bits.
CNT_W, 16, width of the per-requester completion counters (saturating).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req0_valid  in  1  requester 0 has a compare pending.
req0_ready  out  1  requester 0 accepted this cycle when high with req0_valid.
req0_a  in  WIDTH  requester 0 operand A.
req0_b  in  WIDTH  requester 0 operand B.
req0_op  in  1  0 = not-equal, 1 = signed A<B.
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
cmp_a  out  WIDTH  registered operand A to shared comparator.
cmp_b  out  WIDTH  registered operand B to shared comparator.
cmp_neq  in  1  comparator result: A != B (combinational from cmp_a/cmp_b).
cmp_lt  in  1  comparator result: signed A < B.
rsp0_valid  out  1  result for requester 0 available.
rsp0_ready  in  1  requester 0 consumes result.
rsp0_result  out  1  compare result for requester 0.
rsp1_valid, rsp1_ready, rsp1_result  same, for requester 1.
busy  out  1  high whenever state is not IDLE.
done0_cnt  out  CNT_W  completed responses to requester 0.
done1_cnt  out  CNT_W  completed responses to requester 1.

Behaviour:
- Reset (async, immediate): state IDLE, prio pointer 0, cmp_a/cmp_b 0, latched op/id 0, result 0, all rspN_valid 0, done counters 0, busy 0. In-flight operation discarded; no response issued.
- States: IDLE -> EXEC -> HOLD -> IDLE.
- IDLE: grant = sole valid requester; if both valid, grant = prio. reqN_ready = (state==IDLE) & (grant==N) & reqN_valid; at most one ready high per cycle; ready is combinational from valid/state/prio. No valid -> stay IDLE, both ready 0.
- Accept (valid & ready at edge): latch a->cmp_a, b->cmp_b, op, id=grant; prio <= ~grant only when both were valid (otherwise prio unchanged); -> EXEC.
- EXEC (exactly one cycle): comparator settles; at edge, result <= op ? cmp_lt : cmp_neq; -> HOLD.
- HOLD: rsp{id}_valid = 1, other rsp_valid 0, rsp{id}_result = result. Stays until rsp{id}_ready; on handshake: -> IDLE, done{id}_cnt increments, saturating at all-ones.
- Latency: request accepted in cycle t -> rsp_valid high from cycle t+2. With rsp_ready tied high, throughput is one compare per 3 cycles.
- cmp_a/cmp_b hold their value after completion until the next accept (no toggling in IDLE).
- Requester operands may change while valid & !ready; only values at the accepting edge matter. Dropping valid before acceptance is legal and issues nothing.
- rspN_ready while rspN_valid is 0 is ignored. Requests arriving during EXEC/HOLD wait; no queueing beyond the single in-flight op.
- busy = (state != IDLE).

Test Plan:
- Reset mid-HOLD: accept req0 (a=5,b=5,op=0), assert reset in HOLD -> rsp0_valid drops immediately, cmp_a=0, done0_cnt=0, state IDLE, no response after release.
- Single request: req0 a=0x1234,b=0x1235,op=0 accepted cycle 0 -> rsp0_valid high cycle 2, rsp0_result=1, done0_cnt=1; a=b=0xFFFFFFFF -> result 0.
- Signed op: req1 a=0xFFFFFFFF (-1), b=0x00000001, op=1 -> rsp1_result=1; a=0x7FFFFFFF, b=0x80000000 -> rsp1_result=0.
- Contention: both valid continuously, rsp_ready high -> grants alternate 0,1,0,1 from reset (prio 0 first), one response every 3 cycles, never both ready high together.
- Backpressure: rsp0_ready low 5 cycles in HOLD -> rsp0_valid and result stable, req1_ready stays 0, busy 1; then ready -> IDLE next cycle and req1 accepted.
- Counter saturation: force done0_cnt to 0xFFFE, complete 3 req0 ops -> 0xFFFF, 0xFFFF, 0xFFFF.
